// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// valid/acknowledge output holding the last good byte.
module uart_receiver #(
    parameter int INPUT_FEATURES = 8,
    parameter int CLKS_PER_BIT   = 10,
    localparam int CW            = $clog2(INPUT_FEATURES + 1)
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          uart_receive_i,
    input  logic          data_ack_i,
    output logic [7:0]    data_o,
    output logic [CW-1:0] counter_o,
    output logic          data_valid_o,
    output logic          frame_error_o,
    output logic          overrun_o,
    output logic          busy_o,
    output logic [1:0]    state_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_next;
    logic             rx_meta, rx_s, rx_prev;
    logic [CNT_W-1:0] cycle_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             cnt_clear, bit_clear, bit_tick, stop_good, stop_bad;
    logic             fall;

    // Handshake: data_valid_o stays high until the edge where data_ack_i = 1;
    // a good byte landing on that same edge keeps it high with the new data.
    assign fall      = rx_prev & ~rx_s;
    assign busy_o    = (state != IDLE);
    assign state_o   = state;
    assign counter_o = data_o[CW-1:0];

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_receive_i;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        bit_clear  = 1'b0;
        bit_tick   = 1'b0;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                cnt_clear = 1'b1;
                if (fall) state_next = START;
            end
            START: begin
                if (cycle_cnt == HALF_LAST) begin
                    cnt_clear  = 1'b1;
                    bit_clear  = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cycle_cnt == BIT_LAST) begin
                    cnt_clear = 1'b1;
                    bit_tick  = 1'b1;
                    if (bit_cnt == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (cycle_cnt == BIT_LAST) begin
                    cnt_clear  = 1'b1;
                    stop_good  = rx_s;
                    stop_bad   = ~rx_s;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            cycle_cnt <= cnt_clear ? '0 : cycle_cnt + 1'b1;
            if (bit_clear)     bit_cnt <= '0;
            else if (bit_tick) bit_cnt <= bit_cnt + 1'b1;
            if (bit_tick) shift_reg <= {rx_s, shift_reg[7:1]};
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            data_o        <= '0;
            data_valid_o  <= 1'b0;
            frame_error_o <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            frame_error_o <= stop_bad;
            if (stop_good) begin
                data_o       <= shift_reg;
                data_valid_o <= 1'b1;
                if (data_valid_o && !data_ack_i) overrun_o <= 1'b1;
            end else if (data_ack_i) begin
                data_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random
// frames checked against a frame-level model of the receiver outputs.
module tb_uart_receiver;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       line;
    logic       ack;
    logic [7:0] data_o;
    logic [3:0] counter_o;
    logic       data_valid_o, frame_error_o, overrun_o, busy_o;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int valid_rises = 0;
    int fe_cycles = 0;
    int busy_cycles = 0;
    logic prev_valid = 1'b0;

    logic [7:0] exp_q[$];

    uart_receiver #(.INPUT_FEATURES(8), .CLKS_PER_BIT(CPB)) dut (
        .clock_i(clk), .reset_i(reset_i), .uart_receive_i(line),
        .data_ack_i(ack), .data_o(data_o), .counter_o(counter_o),
        .data_valid_o(data_valid_o), .frame_error_o(frame_error_o),
        .overrun_o(overrun_o), .busy_o(busy_o), .state_o(state_o)
    );

    // clock / reset / observation
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid_o && !prev_valid) begin
            rise_cyc    = cyc;
            valid_rises = valid_rises + 1;
        end
        prev_valid = data_valid_o;
        if (frame_error_o) fe_cycles = fe_cycles + 1;
        if (busy_o) busy_cycles = busy_cycles + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b0;
        ack     = 1'b0;
        line    = 1'b1;
        repeat (3) @(negedge clk);
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // One full frame; ack_done pulses ack on the edge the stop bit is sampled.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input bit ack_done, input int gap);
        @(negedge clk);
        start_cyc = cyc;
        line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            repeat (CPB) @(negedge clk);
        end
        line = stop_bit;
        for (int i = 0; i < CPB; i++) begin
            ack = (ack_done && i == 7);
            @(negedge clk);
        end
        ack  = 1'b0;
        line = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        do_reset();
        repeat (100) @(negedge clk);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_o); end
        checks++; if (counter_o !== 4'h0) begin errors++; $display("FAIL reset_counter: got %h want 0", counter_o); end
        checks++; if (data_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", data_valid_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (fe_cycles !== 0) begin errors++; $display("FAIL reset_fe: got %0d pulses want 0", fe_cycles); end
    endtask

    task automatic test_single();
        int lat;
        send_frame(8'h0A, 1'b1, 1'b0, 2);
        lat = rise_cyc - start_cyc;
        checks++; if (lat < 96 || lat > 99) begin errors++; $display("FAIL single_latency: got %0d want 96..99", lat); end
        checks++; if (data_o !== 8'h0A) begin errors++; $display("FAIL single_data: got %h want 0a", data_o); end
        checks++; if (counter_o !== 4'hA) begin errors++; $display("FAIL single_counter: got %h want a", counter_o); end
        checks++; if (data_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", data_valid_o); end
        pulse_ack();
        checks++; if (data_valid_o !== 1'b0) begin errors++; $display("FAIL single_ack: got %b want 0", data_valid_o); end
    endtask

    task automatic test_loopback();
        logic [3:0] cnt_in[2];
        cnt_in[0] = 4'b1010;
        cnt_in[1] = 4'b1110;
        for (int i = 0; i < 2; i++) begin
            send_frame({4'h0, cnt_in[i]}, 1'b1, 1'b0, 3);
            checks++; if (counter_o !== cnt_in[i]) begin errors++; $display("FAIL loop_counter%0d: got %h want %h", i, counter_o, cnt_in[i]); end
            pulse_ack();
        end
        checks++; if (fe_cycles !== 0 || overrun_o !== 1'b0) begin errors++; $display("FAIL loop_errors: got fe=%0d ovr=%b want 0/0", fe_cycles, overrun_o); end
    endtask

    task automatic test_glitch();
        int rises0;
        rises0 = valid_rises;
        busy_cycles = 0;
        @(negedge clk);
        line = 1'b0;
        repeat (3) @(negedge clk);
        line = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (busy_cycles !== 5) begin errors++; $display("FAIL glitch_busy: got %0d cycles want 5", busy_cycles); end
        checks++; if (valid_rises !== rises0 || data_valid_o !== 1'b0) begin errors++; $display("FAIL glitch_valid: got rises=%0d want %0d", valid_rises, rises0); end
    endtask

    task automatic test_frame_error();
        do_reset();
        fe_cycles = 0;
        send_frame(8'h55, 1'b0, 1'b0, 3);
        checks++; if (fe_cycles !== 1) begin errors++; $display("FAIL fe_pulse: got %0d cycles want 1", fe_cycles); end
        checks++; if (data_valid_o !== 1'b0) begin errors++; $display("FAIL fe_valid: got %b want 0", data_valid_o); end
        send_frame(8'h33, 1'b1, 1'b0, 3);
        checks++; if (data_o !== 8'h33 || data_valid_o !== 1'b1) begin errors++; $display("FAIL fe_recover: got %h/%b want 33/1", data_o, data_valid_o); end
        pulse_ack();
    endtask

    task automatic test_back_to_back(input bit ack_last);
        logic exp_ovr;
        exp_ovr = !ack_last;
        do_reset();
        send_frame(8'h12, 1'b1, 1'b0, 0);
        send_frame(8'h34, 1'b1, ack_last, 3);
        checks++; if (data_o !== 8'h34) begin errors++; $display("FAIL b2b_data(ack=%0d): got %h want 34", ack_last, data_o); end
        checks++; if (overrun_o !== exp_ovr) begin errors++; $display("FAIL b2b_overrun(ack=%0d): got %b want %b", ack_last, overrun_o, exp_ovr); end
        checks++; if (data_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid(ack=%0d): got %b want 1", ack_last, data_valid_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(8'h77, 1'b1, 1'b0, 3);
        @(negedge clk);
        line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            line = i[0];
            repeat (CPB) @(negedge clk);
        end
        reset_i = 1'b0;
        #1;
        checks++; if (data_o !== 8'h00 || data_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got %h/%b/%b want 00/0/0", data_o, data_valid_o, busy_o); end
        line = 1'b1;
        repeat (3) @(negedge clk);
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'hA5, 1'b1, 1'b0, 3);
        checks++; if (data_o !== 8'hA5 || data_valid_o !== 1'b1 || overrun_o !== 1'b0) begin errors++; $display("FAIL midreset_frame: got %h/%b/%b want a5/1/0", data_o, data_valid_o, overrun_o); end
    endtask

    // Random frames against a frame-level model of data/valid/overrun/errors.
    task automatic test_random();
        logic [7:0] b, exp_data;
        logic       exp_valid, exp_ovr, stop_bit;
        int         exp_fe;
        do_reset();
        fe_cycles = 0;
        exp_data = 8'h00; exp_valid = 1'b0; exp_ovr = 1'b0; exp_fe = 0;
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom_range(0, 255));
            stop_bit = ($urandom_range(0, 4) != 0);
            send_frame(b, stop_bit, 1'b0, $urandom_range(2, 15));
            if (stop_bit) begin
                if (exp_valid) exp_ovr = 1'b1;
                exp_valid = 1'b1;
                exp_q.push_back(b);
                exp_data = exp_q.pop_front();
            end else begin
                exp_fe++;
            end
            checks++; if (data_o !== exp_data || data_valid_o !== exp_valid) begin errors++; $display("FAIL rand_data[%0d]: got %h/%b want %h/%b", n, data_o, data_valid_o, exp_data, exp_valid); end
            checks++; if (overrun_o !== exp_ovr || fe_cycles !== exp_fe) begin errors++; $display("FAIL rand_flags[%0d]: got ovr=%b fe=%0d want %b/%0d", n, overrun_o, fe_cycles, exp_ovr, exp_fe); end
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                exp_valid = 1'b0;
                checks++; if (data_valid_o !== exp_valid) begin errors++; $display("FAIL rand_ack[%0d]: got %b want 0", n, data_valid_o); end
            end
        end
    endtask

    initial begin
        reset_i = 1'b1;
        line    = 1'b1;
        ack     = 1'b0;
        test_reset();
        test_single();
        test_loopback();
        test_glitch();
        test_frame_error();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
